// File: rtl/snitch_pkg.sv
// Shared data-port types for the Snitch address demultiplexer.
package snitch_pkg;

    localparam int unsigned DataWidth = 32;
    localparam int unsigned AddrBits  = 32;

    // Data-port request: the demux only looks at addr and write.
    typedef struct packed {
        logic [AddrBits-1:0]    addr;
        logic                   write;
        logic [DataWidth-1:0]   data;
        logic [DataWidth/8-1:0] strb;
    } dreq_t;

    // Data-port response: write echoes the request kind, error flags a fault.
    typedef struct packed {
        logic [DataWidth-1:0] data;
        logic                 write;
        logic                 error;
    } dresp_t;

    // Address rule; a target matches when (addr & mask) == base.
    typedef struct packed {
        logic [AddrBits-1:0] base;
        logic [AddrBits-1:0] mask;
    } addr_rule_t;

endpackage

// File: rtl/fifo_v3.sv
// Small first-word-fall-through FIFO with occupancy counter and flush.
module fifo_v3 #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    output logic                  full_o,
    output logic                  empty_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    localparam int unsigned PtrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntWidth = $clog2(DEPTH + 1);

    logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  do_push, do_pop;

    assign full_o  = (cnt_q == CntWidth'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Next-state pointers and occupancy, with explicit wrap for any depth.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PtrWidth'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PtrWidth'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    // Pointer and counter state; reset empties the queue.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read once counted in.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/snitch_addr_decode.sv
// Address rule matcher: lowest matching rule index plus a no-match flag.
module snitch_addr_decode #(
    parameter int unsigned NrOutputs = 2,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned SelWidth  = 2
) (
    input  logic [AddrWidth-1:0]                addr_i,
    input  logic [NrOutputs-1:0][AddrWidth-1:0] rule_base_i,
    input  logic [NrOutputs-1:0][AddrWidth-1:0] rule_mask_i,
    output logic [SelWidth-1:0]                 idx_o,
    output logic                                no_match_o
);

    logic [NrOutputs-1:0] match;

    for (genvar gi = 0; gi < NrOutputs; gi++) begin : g_match
        assign match[gi] = ((addr_i & rule_mask_i[gi]) == rule_base_i[gi]);
    end

    // Priority encode: scan downwards so the lowest matching index wins.
    // With a single output this degenerates to "index 0, matched or not".
    always_comb begin
        idx_o      = '0;
        no_match_o = 1'b1;
        for (int i = int'(NrOutputs) - 1; i >= 0; i--) begin
            if (match[i]) begin
                idx_o      = SelWidth'(i);
                no_match_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/snitch_addr_demux.sv
// Address-based 1-to-N request demultiplexer with in-order response merge.
// Build option: define SNITCH_ADDR_DEMUX_ERR_EN to answer unmatched
// addresses locally with an error response instead of using DefaultPort.
module snitch_addr_demux
    import snitch_pkg::*;
#(
    parameter int unsigned NrOutputs   = 2,
    parameter int unsigned AddrWidth   = 32,
    parameter type         req_t       = dreq_t,
    parameter type         resp_t      = dresp_t,
    parameter int unsigned RespDepth   = 8,
    parameter int unsigned DefaultPort = 0
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic [NrOutputs-1:0][AddrWidth-1:0] rule_base_i,
    input  logic [NrOutputs-1:0][AddrWidth-1:0] rule_mask_i,
    input  req_t                                req_payload_i,
    input  logic                                req_valid_i,
    output logic                                req_ready_o,
    output resp_t                               resp_payload_o,
    output logic                                resp_last_o,
    output logic                                resp_valid_o,
    input  logic                                resp_ready_i,
    output req_t  [NrOutputs-1:0]               req_payload_o,
    output logic  [NrOutputs-1:0]               req_valid_o,
    input  logic  [NrOutputs-1:0]               req_ready_i,
    input  resp_t [NrOutputs-1:0]               resp_payload_i,
    input  logic  [NrOutputs-1:0]               resp_last_i,
    input  logic  [NrOutputs-1:0]               resp_valid_i,
    output logic  [NrOutputs-1:0]               resp_ready_o
);

    // One extra code point so the local error responder has its own index.
    localparam int unsigned SelWidth  = $clog2(NrOutputs + 1);
    localparam int unsigned FifoWidth = SelWidth + 1;

    logic [SelWidth-1:0]  dec_idx;
    logic                 dec_no_match;
    logic [SelWidth-1:0]  sel;
    logic                 route_local;
    logic                 fifo_full, fifo_empty;
    logic                 accept_en;
    logic                 push, pop;
    logic [FifoWidth-1:0] head;
    logic [SelWidth-1:0]  head_sel;
    logic                 head_write;

    snitch_addr_decode #(
        .NrOutputs (NrOutputs),
        .AddrWidth (AddrWidth),
        .SelWidth  (SelWidth)
    ) i_decode (
        .addr_i      (req_payload_i.addr),
        .rule_base_i (rule_base_i),
        .rule_mask_i (rule_mask_i),
        .idx_o       (dec_idx),
        .no_match_o  (dec_no_match)
    );

`ifdef SNITCH_ADDR_DEMUX_ERR_EN
    assign sel         = dec_no_match ? SelWidth'(NrOutputs) : dec_idx;
    assign route_local = dec_no_match;
`else
    assign sel         = dec_no_match ? SelWidth'(DefaultPort) : dec_idx;
    assign route_local = 1'b0;
`endif

    // Reset gates the handshake so nothing is offered while rst_ni is low.
    assign accept_en = rst_ni & ~fifo_full;

    for (genvar gi = 0; gi < NrOutputs; gi++) begin : g_bcast
        assign req_payload_o[gi] = req_payload_i;
    end

    // Request steering: only the selected target sees valid.
    always_comb begin
        req_valid_o = '0;
        req_ready_o = 1'b0;
        if (route_local) begin
            req_ready_o = accept_en;
        end else begin
            for (int unsigned j = 0; j < NrOutputs; j++) begin
                if (sel == SelWidth'(j)) begin
                    req_valid_o[j] = req_valid_i & accept_en;
                    req_ready_o    = req_ready_i[j] & accept_en;
                end
            end
        end
    end

    assign push = req_valid_i & req_ready_o;

    fifo_v3 #(
        .DATA_WIDTH (FifoWidth),
        .DEPTH      (RespDepth)
    ) i_order_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (1'b0),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .data_i  ({sel, req_payload_i.write}),
        .push_i  (push),
        .data_o  (head),
        .pop_i   (pop)
    );

    assign head_sel   = head[FifoWidth-1:1];
    assign head_write = head[0];

    // Response merge: only the head target may complete; others stall.
    always_comb begin
        resp_payload_o = resp_payload_i[0];
        resp_last_o    = 1'b0;
        resp_valid_o   = 1'b0;
        resp_ready_o   = '0;
        for (int unsigned j = 0; j < NrOutputs; j++) begin
            if (head_sel == SelWidth'(j)) begin
                resp_payload_o = resp_payload_i[j];
                resp_last_o    = resp_last_i[j];
                if (!fifo_empty) begin
                    resp_valid_o    = resp_valid_i[j];
                    resp_ready_o[j] = resp_ready_i;
                end
            end
        end
`ifdef SNITCH_ADDR_DEMUX_ERR_EN
        if (head_sel == SelWidth'(NrOutputs)) begin
            resp_payload_o       = '0;
            resp_payload_o.error = 1'b1;
            resp_payload_o.write = head_write;
            resp_last_o          = 1'b1;
            resp_valid_o         = ~fifo_empty;
        end
`endif
    end

    // Multi-beat responses keep the head until their last beat retires.
    assign pop = resp_valid_o & resp_ready_i & resp_last_o;

`ifndef SYNTHESIS
    // Targets must not answer when nothing is outstanding.
    a_no_orphan_resp: assert property (@(posedge clk_i) disable iff (!rst_ni)
        fifo_empty |-> (resp_valid_i == '0));

    // Rules must stay put while a request waits, or sel could move under it.
    a_rules_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (req_valid_i && !req_ready_o) |=> ($stable(rule_base_i) && $stable(rule_mask_i)));

    // A delivered response must be of the same kind as the request it answers.
    a_resp_kind: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (resp_valid_o && !fifo_empty) |-> (resp_payload_o.write == head_write));
`endif

endmodule

// File: tb/tb_snitch_addr_demux.sv
// Directed bench for snitch_addr_demux with an in-order response scoreboard.
module tb_snitch_addr_demux;
    import snitch_pkg::*;

    localparam int          DEPTH = 8;
    localparam logic [31:0] KEY   = 32'h5A5A_0000;
`ifdef SNITCH_ADDR_DEMUX_ERR_EN
    localparam int UNMATCHED_PORT = 2;
`else
    localparam int UNMATCHED_PORT = 0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [1:0][31:0]  rule_base_i, rule_mask_i;
    dreq_t             req_payload_i;
    logic              req_valid_i, req_ready_o;
    dresp_t            resp_payload_o;
    logic              resp_last_o, resp_valid_o, resp_ready_i;
    dreq_t  [1:0]      req_payload_o;
    logic   [1:0]      req_valid_o, req_ready_i;
    dresp_t [1:0]      resp_payload_i;
    logic   [1:0]      resp_last_i, resp_valid_i, resp_ready_o;

    snitch_addr_demux #(
        .NrOutputs   (2),
        .AddrWidth   (32),
        .req_t       (dreq_t),
        .resp_t      (dresp_t),
        .RespDepth   (DEPTH),
        .DefaultPort (0)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .rule_base_i    (rule_base_i),
        .rule_mask_i    (rule_mask_i),
        .req_payload_i  (req_payload_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .resp_payload_o (resp_payload_o),
        .resp_last_o    (resp_last_o),
        .resp_valid_o   (resp_valid_o),
        .resp_ready_i   (resp_ready_i),
        .req_payload_o  (req_payload_o),
        .req_valid_o    (req_valid_o),
        .req_ready_i    (req_ready_i),
        .resp_payload_i (resp_payload_i),
        .resp_last_i    (resp_last_i),
        .resp_valid_i   (resp_valid_i),
        .resp_ready_o   (resp_ready_o)
    );

    always #5 clk_i = ~clk_i;

    // Scoreboard entry: expected upstream response, in request order.
    typedef struct {
        int          port;
        logic [31:0] data;
        logic        write;
        logic        err;
    } exp_t;

    // Target-side record of a request the target has accepted.
    typedef struct {
        logic [31:0] data;
        logic        write;
    } tgt_t;

    exp_t sb [$];
    tgt_t tq [2][$];
    int   nb [2];
    int   pbeat [2];
    int   sb_beat;
    int   cur_port;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [31:0] addr, input logic write, input int port);
        req_payload_i.addr  = addr;
        req_payload_i.write = write;
        req_payload_i.data  = addr + 32'd1;
        req_payload_i.strb  = 4'hF;
        req_valid_i         = 1'b1;
        cur_port            = port;
    endtask

    task automatic clear_req();
        req_valid_i = 1'b0;
    endtask

    // One clock cycle: called just after a falling edge, returns at the next.
    task automatic tick();
        logic        full, exp_rdy, exp_rv, exp_last, fire_req, fire_rsp;
        logic [1:0]  exp_vld, exp_rr, clr_mask;
        logic [31:0] a;
        logic        w;
        int          hp;
        // Targets present their head-of-queue data plus beat number.
        for (int p = 0; p < 2; p++) begin
            if (tq[p].size() > 0) begin
                resp_payload_i[p].data  = tq[p][0].data + 32'(pbeat[p]);
                resp_payload_i[p].write = tq[p][0].write;
                resp_payload_i[p].error = 1'b0;
                resp_last_i[p]          = (pbeat[p] == nb[p] - 1);
            end else begin
                resp_payload_i[p] = '0;
                resp_last_i[p]    = 1'b0;
            end
        end
        #1;
        full     = (sb.size() >= DEPTH);
        exp_rdy  = !full && ((cur_port == 2) ? 1'b1 : req_ready_i[cur_port]);
        exp_vld  = (req_valid_i && !full && cur_port < 2) ? 2'(1 << cur_port) : 2'b00;
        hp       = (sb.size() > 0) ? sb[0].port : -1;
        exp_rr   = (hp == 0 || hp == 1) && resp_ready_i ? 2'(1 << hp) : 2'b00;
        exp_rv   = (hp == 2) || ((hp == 0 || hp == 1) && resp_valid_i[hp]);
        exp_last = (hp == 2) ? 1'b1 : ((hp >= 0) && (sb_beat == nb[hp < 2 ? hp : 0] - 1));
        chk("req_ready", 64'(req_ready_o), 64'(exp_rdy));
        chk("req_valid", 64'(req_valid_o), 64'(exp_vld));
        chk("resp_valid", 64'(resp_valid_o), 64'(exp_rv));
        chk("resp_ready", 64'(resp_ready_o), 64'(exp_rr));
        if (req_valid_i) begin
            chk("req_bcast_addr", {req_payload_o[1].addr, req_payload_o[0].addr},
                {req_payload_i.addr, req_payload_i.addr});
        end
        if (exp_rv) begin
            chk("resp_data", 64'(resp_payload_o.data), 64'(sb[0].data + 32'(sb_beat)));
            chk("resp_write", 64'(resp_payload_o.write), 64'(sb[0].write));
            chk("resp_error", 64'(resp_payload_o.error), 64'(sb[0].err));
            chk("resp_last", 64'(resp_last_o), 64'(exp_last));
        end
        fire_req = req_valid_i && exp_rdy;
        fire_rsp = exp_rv && resp_ready_i;
        a        = req_payload_i.addr;
        w        = req_payload_i.write;
        clr_mask = 2'b00;
        @(posedge clk_i);
        if (fire_req) begin
            sb.push_back('{port: cur_port, data: (cur_port == 2) ? 32'h0 : (a ^ KEY),
                           write: w, err: (cur_port == 2)});
            if (cur_port < 2) tq[cur_port].push_back('{data: a ^ KEY, write: w});
        end
        if (fire_rsp) begin
            if (exp_last) begin
                void'(sb.pop_front());
                sb_beat = 0;
                if (hp < 2) begin
                    void'(tq[hp].pop_front());
                    pbeat[hp]    = 0;
                    clr_mask[hp] = 1'b1;
                end
            end else begin
                sb_beat++;
                pbeat[hp]++;
            end
        end
        @(negedge clk_i);
        resp_valid_i = resp_valid_i & ~clr_mask;
    endtask

    // Let every target with pending work respond until the scoreboard empties.
    task automatic drain();
        int guard = 0;
        while (sb.size() > 0 && guard < 64) begin
            for (int p = 0; p < 2; p++) resp_valid_i[p] = (tq[p].size() > 0);
            tick();
            guard++;
        end
        chk("drain_left", 64'(sb.size()), 64'd0);
        resp_valid_i = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rule_base_i[0] = 32'h0000_0000; rule_mask_i[0] = 32'hFFFF_0000;
        rule_base_i[1] = 32'h0001_0000; rule_mask_i[1] = 32'hFFFF_0000;
        rst_ni         = 1'b0;
        req_payload_i  = '0;
        req_valid_i    = 1'b0;
        req_ready_i    = 2'b11;
        resp_ready_i   = 1'b1;
        resp_payload_i = '0;
        resp_last_i    = 2'b00;
        resp_valid_i   = 2'b00;
        nb[0] = 1; nb[1] = 1; pbeat[0] = 0; pbeat[1] = 0; sb_beat = 0; cur_port = 0;

        // Reset state
        @(negedge clk_i); @(negedge clk_i);
        chk("rst_req_ready", 64'(req_ready_o), 64'd0);
        chk("rst_req_valid", 64'(req_valid_o), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
        chk("rst_resp_ready", 64'(resp_ready_o), 64'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        $display("reset released");

        // Routing and ordering: port1 answers first and is held off
        set_req(32'h0000_0010, 1'b0, 0); tick();
        set_req(32'h0001_0020, 1'b0, 1); tick();
        clear_req();
        resp_valid_i = 2'b10; tick(); tick();
        resp_valid_i = 2'b11; tick();
        tick();
        chk("t1_sb_empty", 64'(sb.size()), 64'd0);
        $display("txn routing/ordering done");

        // Target backpressure: no push while the selected target is not ready
        req_ready_i = 2'b01;
        set_req(32'h0001_0030, 1'b0, 1); tick();
        req_ready_i = 2'b11;
        tick();
        clear_req();
        drain();
        $display("txn backpressure done");

        // Fill: eight outstanding, ninth refused, accepted one cycle after a pop
        for (int i = 0; i < 8; i++) begin
            set_req(((i % 2) == 1) ? 32'h0001_0000 + 32'(i * 4) : 32'(i * 4), 1'b0, i % 2);
            tick();
        end
        set_req(32'h0000_0040, 1'b0, 0);
        tick();
        resp_valid_i = 2'b01; tick();
        tick();
        clear_req();
        chk("fill_occupancy", 64'(sb.size()), 64'd8);
        drain();
        $display("txn fill done");

        // Multi-beat: port1 three beats ahead of a waiting port0 response
        nb[1] = 3;
        set_req(32'h0001_0100, 1'b0, 1); tick();
        set_req(32'h0000_0100, 1'b0, 0); tick();
        clear_req();
        drain();
        nb[1] = 1;
        $display("txn multi-beat done");

        // Simultaneous push and pop at occupancy 4
        for (int i = 0; i < 4; i++) begin
            set_req(((i % 2) == 1) ? 32'h0001_0200 + 32'(i * 4) : 32'h200 + 32'(i * 4), 1'b0, i % 2);
            tick();
        end
        set_req(32'h0001_0300, 1'b0, 1);
        resp_valid_i = 2'b01;
        tick();
        chk("simul_occupancy", 64'(sb.size()), 64'd4);
        // Occupancy check through the DUT: exactly four more fit
        for (int i = 0; i < 5; i++) begin
            set_req(32'h0000_0400 + 32'(i * 4), 1'b0, 0);
            tick();
        end
        clear_req();
        drain();
        $display("txn simultaneous done");

        // Unmatched address (write)
        set_req(32'h8000_0000, 1'b1, UNMATCHED_PORT); tick();
        clear_req();
        drain();
        $display("txn unmatched done");

        // Reset with three outstanding
        set_req(32'h0000_0500, 1'b0, 0); tick();
        set_req(32'h0001_0500, 1'b0, 1); tick();
        set_req(32'h0000_0504, 1'b0, 0); tick();
        set_req(32'h0001_0504, 1'b0, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("mid_rst_req_valid", 64'(req_valid_o), 64'd0);
        chk("mid_rst_req_ready", 64'(req_ready_o), 64'd0);
        chk("mid_rst_resp_valid", 64'(resp_valid_o), 64'd0);
        chk("mid_rst_resp_ready", 64'(resp_ready_o), 64'd0);
        sb.delete(); tq[0].delete(); tq[1].delete();
        pbeat[0] = 0; pbeat[1] = 0; sb_beat = 0;
        resp_valid_i = 2'b00;
        clear_req();
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        set_req(32'h0001_0040, 1'b0, 1); tick();
        clear_req();
        drain();
        $display("txn reset recovery done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/snitch_addr_demux.md
Name: snitch_addr_demux

Overview:
- Initiator-side counterpart of the N-to-1 request arbiter.
- Takes one request/response port from a core or arbiter and steers each request to one of NrOutputs target ports by address-rule match.
- Merges target responses back onto the single response port in strict request order.
- Sits between a Snitch data port and multiple memory-side targets (TCDM, peripherals, AXI bridge).

Parameters:
- NrOutputs, 2, number of target ports (>=1).
- AddrWidth, 32, width of the req_t.addr field and of the rule ports.
- req_t, snitch_pkg::dreq_t, request payload; must contain addr and write.
- resp_t, snitch_pkg::dresp_t, response payload; must contain write and error.
- RespDepth, 8, maximum outstanding requests (ordering FIFO depth, >=2).
- DefaultPort, 0, target used when no rule matches.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- rule_base_i  in  NrOutputs x AddrWidth  per-target match base
- rule_mask_i  in  NrOutputs x AddrWidth  per-target match mask
- req_payload_i  in  req_t  upstream request
- req_valid_i  in  1  upstream request valid
- req_ready_o  out  1  upstream request ready
- resp_payload_o  out  resp_t  upstream response
- resp_last_o  out  1  last beat of response
- resp_valid_o  out  1  upstream response valid
- resp_ready_i  in  1  upstream response ready
- req_payload_o  out  NrOutputs x req_t  per-target request (broadcast payload)
- req_valid_o  out  NrOutputs  per-target request valid
- req_ready_i  in  NrOutputs  per-target request ready
- resp_payload_i  in  NrOutputs x resp_t  per-target response
- resp_last_i  in  NrOutputs  per-target last
- resp_valid_i  in  NrOutputs  per-target response valid
- resp_ready_o  out  NrOutputs  per-target response ready

Behaviour:
- Clock and reset: one clock clk_i; reset rst_ni is asynchronous, active-low.
- Decode: target i matches when (req_payload_i.addr & rule_mask_i[i]) == rule_base_i[i]. The lowest matching index wins. No match selects DefaultPort.
- Request path is combinational, with zero added latency:
  - req_valid_o[sel] = req_valid_i & ~full; all other req_valid_o bits are 0.
  - req_ready_o = req_ready_i[sel] & ~full.
  - req_payload_o[j] = req_payload_i for all j.
- Ordering FIFO (fifo_v3, width clog2(NrOutputs+1)+1): on each upstream request handshake, push {sel, write}.
  - full blocks new requests. A pop in the same cycle does not relieve full, so there is no push-on-full.
- Response path, with head = FIFO output and FIFO non-empty:
  - resp_valid_o = resp_valid_i[head].
  - resp_payload_o = resp_payload_i[head], resp_last_o = resp_last_i[head].
  - resp_ready_o[head] = resp_ready_i; every other resp_ready_o bit is 0.
  - Pop on resp_valid_o & resp_ready_i & resp_last_o. Multi-beat responses hold head until last.
- Empty FIFO: resp_valid_o = 0 and all resp_ready_o = 0. A response from any target is ignored and held off; this is an assertion error.
- Out-of-order responses: a non-head target asserting valid is stalled (ready=0) until it becomes head.
- Simultaneous push and pop: both occur, and occupancy is unchanged.
- Upstream must keep payload stable while valid is asserted. sel may then change only if the rules change, which is illegal while valid=1 (assertion).
- Reset values: all valid/ready outputs 0, FIFO empty, payload outputs follow inputs.
- Reset mid-operation: outstanding entries are discarded. Targets must be reset in the same domain.
- NrOutputs==1: no decode; the FIFO is kept only for full/last accounting.

Optional Feature:
- Macro: SNITCH_ADDR_DEMUX_ERR_EN.
- With the macro defined:
  - An unmatched address does not go to DefaultPort. It is accepted locally (req_ready_o = ~full) and pushes the pseudo-index NrOutputs.
  - When that entry reaches head, the block drives a one-beat response with resp_valid_o=1, resp_last_o=1, payload '0, error=1, and write equal to the stored write bit.
  - The entry pops on resp_ready_i.
- Without the macro: unmatched addresses route to DefaultPort and the error path is not synthesized.

Decomposition:
- snitch_pkg holds dreq_t/dresp_t, which must carry the addr, write and error fields. It also holds an addr_rule_t {base, mask} typedef; rule ports may later be converted to addr_rule_t arrays.
- One sub-module, snitch_addr_decode: combinational rule match, priority encode and default/no-match flag.
- The ordering FIFO reuses common_cells fifo_v3.

Test Plan:
- Directed test 1 (routing and ordering), with NrOutputs=2, rules port0 base 0x0000_0000 mask 0xFFFF_0000 and port1 base 0x0001_0000 mask 0xFFFF_0000:
  - Stimulus: read 0x0000_0010, then read 0x0001_0020.
  - Response: req_valid_o toggles 01 then 10.
  - Port1 responds first and is stalled (resp_ready_o[1]=0) until port0 responds. Upstream receives port0 data, then port1 data.
- Fill: issue 8 reads with no responses. Require req_ready_o=0 on the 9th. One response pops; the next request is accepted one cycle later.
- Multi-beat: port1 returns 3 beats, last on beat 3. Head stays 1 for 3 handshakes; a port0 response waiting behind it is delivered afterwards.
- Simultaneous: at occupancy 4, request and last-response handshake in the same cycle. Occupancy stays 4 and no entry is lost.
- Unmatched address 0x8000_0000:
  - Without the macro, it goes to DefaultPort 0.
  - With SNITCH_ADDR_DEMUX_ERR_EN and a write, it is accepted with no req_valid_o set. The next response has error=1, write=1, last=1.
- Reset asserted with 3 outstanding: all valid/ready outputs go 0 asynchronously. After release, a new read to port1 routes correctly and its response returns unblocked.
